// File: rtl/nf_in_debounce.sv
// Board-input reader: 2-flop synchronizer plus per-bit debounce with sticky rise/fall flags.
// Optional masked interrupt output is enabled by defining NF_IN_DEBOUNCE_IRQ_EN.
module nf_in_debounce #(
    parameter int              IN_W      = 12,
    parameter int              DB_CYCLES = 500000,
    parameter logic [IN_W-1:0] INIT_VAL  = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [IN_W-1:0] in_raw,
    output logic [IN_W-1:0] in_stable,
    output logic [IN_W-1:0] rise_ev,
    output logic [IN_W-1:0] fall_ev,
    input  logic [IN_W-1:0] ev_clr,
    output logic            ev_any
`ifdef NF_IN_DEBOUNCE_IRQ_EN
    ,
    input  logic [IN_W-1:0] irq_mask,
    output logic            irq
`endif
);

    localparam int              CW     = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_TC = CW'(DB_CYCLES - 1);

    logic [IN_W-1:0] sync_q1;
    logic [IN_W-1:0] sync_q2;
    logic [IN_W-1:0] accept;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= INIT_VAL;
            sync_q2 <= INIT_VAL;
        end else begin
            sync_q1 <= in_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Counter tracks consecutive cycles the synchronized level disagrees with
    // the accepted level; any agreement or an acceptance restarts it.
    genvar g;
    generate
        for (g = 0; g < IN_W; g++) begin : g_bit
            logic [CW-1:0] cnt_q;
            logic          mismatch;

            assign mismatch  = sync_q2[g] ^ in_stable[g];
            assign accept[g] = mismatch && (cnt_q == CNT_TC);

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt_q <= '0;
                end else if (!mismatch || accept[g]) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    endgenerate

    // A new event takes priority over a clear landing in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_stable <= INIT_VAL;
            rise_ev   <= '0;
            fall_ev   <= '0;
            ev_any    <= 1'b0;
        end else begin
            in_stable <= in_stable ^ accept;
            rise_ev   <= (accept &  sync_q2) | (rise_ev & ~ev_clr);
            fall_ev   <= (accept & ~sync_q2) | (fall_ev & ~ev_clr);
            ev_any    <= |(rise_ev | fall_ev);
        end
    end

`ifdef NF_IN_DEBOUNCE_IRQ_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq <= 1'b0;
        end else begin
            irq <= |((rise_ev | fall_ev) & irq_mask);
        end
    end
`endif

endmodule

// File: doc/nf_in_debounce.md
Name: nf_in_debounce

Overview:
- Board-input reader: the inbound counterpart of the board's display/LED output path.
- Samples raw asynchronous switch and push-button levels from the board pins.
- Synchronizes and debounces each bit independently, then presents clean levels plus sticky rise/fall event flags to the core-side GPIO input.
- Sits between the board top's sw/key pins and the core's gpio_i_* inputs.

Parameters:
- IN_W, 12, number of independent inputs (10 switches + 2 keys).
- DB_CYCLES, 500000, consecutive clock cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); legal range >= 1.
- INIT_VAL, '0, IN_W-bit reset value of the synchronizer flops and in_stable (set key bits to 1 for active-low buttons).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- in_raw  input  IN_W  raw pin levels, asynchronous to clk.
- in_stable  output  IN_W  debounced levels.
- rise_ev  output  IN_W  sticky flag: debounced 0->1 occurred.
- fall_ev  output  IN_W  sticky flag: debounced 1->0 occurred.
- ev_clr  input  IN_W  single-cycle per-bit clear for rise_ev/fall_ev.
- ev_any  output  1  OR of all rise_ev and fall_ev bits.

Behaviour:
- Reset (resetn low, asynchronous):
  - both synchronizer stages and in_stable = INIT_VAL;
  - all debounce counters = 0;
  - rise_ev = fall_ev = 0; ev_any = 0.
  - Deasserting reset mid-debounce discards all progress; no events are generated by reset itself.
- Synchronizer:
  - 2-flop chain per bit; s = second stage.
  - No combinational path from in_raw to any output.
- Debounce, per bit i, counter width $clog2(DB_CYCLES+1):
  - If s[i] == in_stable[i]: counter = 0.
  - Else if counter == DB_CYCLES-1: in_stable[i] <= s[i], counter <= 0, corresponding event set.
  - Else: counter increments.
- Latency: a clean level change on in_raw appears on in_stable exactly DB_CYCLES+2 clock edges after the first edge that samples it.
- Glitch rejection:
  - Any pulse on s shorter than DB_CYCLES cycles resets the counter; in_stable is unchanged and no event is raised.
  - A bouncing input restarts the count on every return to the stable level.
- Counter never wraps: it is always cleared on acceptance or on a match.
- Events:
  - rise_ev[i] is set in the same cycle in_stable[i] goes 0->1; fall_ev[i] likewise for 1->0.
  - Flags stay set until ev_clr[i] is sampled high; ev_clr clears both flags of bit i.
  - Set and ev_clr in the same cycle: set wins, flag stays 1.
  - Rise and fall flags may both be set if the core has not cleared them between transitions.
- ev_any: registered, asserts one cycle after any flag sets; deasserts one cycle after the last flag clears.
- DB_CYCLES = 1: in_stable follows s with one cycle delay, so total latency is 3 edges.

Optional Feature:
- Macro: NF_IN_DEBOUNCE_IRQ_EN.
- When defined:
  - adds input irq_mask (IN_W) and output irq (1).
  - irq is registered, = |((rise_ev | fall_ev) & irq_mask), reset 0.
  - irq is level-held until the masked flags are cleared.
- When undefined: irq_mask and irq ports do not exist; all other behaviour is identical.

Test Plan (DB_CYCLES=4, IN_W=12, INIT_VAL=12'h0C00):
- Reset check: hold resetn=0, in_raw=12'h0C00 -> in_stable=12'h0C00, rise_ev=fall_ev=0, ev_any=0. Release reset with no input change -> no events for 100 cycles.
- Clean rise: in_raw[0] 0->1 held -> in_stable[0]=1 on the 6th edge, rise_ev[0]=1 the same cycle, ev_any=1 one cycle later.
- Glitch rejection:
  - in_raw[3] high for 3 cycles then low -> in_stable[3] stays 0, no events.
  - Bounce pattern 1,1,0,1,1,1,1 -> accepted only after the final 4 consecutive highs.
- Clear/set collision: hold rise_ev[0]=1; pulse ev_clr[0] in the same cycle a new fall on bit 0 is accepted -> fall_ev[0]=1 (set wins) and rise_ev[0]=0.
- Async reset mid-debounce: bit 5 counter at 2, assert resetn low -> counter 0, in_stable[5]=0 immediately. After release, input still high -> accepted DB_CYCLES+2 edges after release.
- IRQ (macro defined): irq_mask=12'h001, rise on bit 1 -> irq stays 0. Rise on bit 0 -> irq=1 one cycle after rise_ev[0]. ev_clr[0] pulse -> irq=0 one cycle after the flag clears.
